// File: rtl/lane_deskew_ctrl_pkg.sv
// Shared types and constants for the lane deskew controller.
// Holds the lane count, the sync byte, the default per-lane tap (DSKEW),
// the per-lane bus typedefs, the controller state enum and the eye-center helper.
package lane_deskew_ctrl_pkg;

  localparam int unsigned NUM_LANE = 4;
  localparam int unsigned TAP_W    = 5;
  localparam int unsigned RUN_W    = 6;
  localparam int unsigned LANE_W   = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef logic [NUM_LANE-1:0]            lane_vld_t;
  typedef logic [NUM_LANE-1:0][7:0]       lane_data_t;
  typedef logic [NUM_LANE-1:0][TAP_W-1:0] lane_dly_t;

  typedef logic [TAP_W-1:0]  tap_t;
  typedef logic [RUN_W-1:0]  run_t;
  typedef logic [LANE_W-1:0] lane_idx_t;

  localparam tap_t      MAX_TAP = 5'd31;
  localparam lane_dly_t DSKEW   = {NUM_LANE{5'd3}};

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StObserve,
    StEval,
    StNext,
    StFinish
  } deskew_state_e;

  // Center of a run of good taps: start + (len-1)/2. len is 1..32 and the run
  // lies inside 0..31, so the half-width fits 4 bits and the sum cannot overflow.
  function automatic tap_t center_tap(input tap_t start, input run_t len);
    tap_t half;
    half = tap_t'((len - run_t'(1)) >> 1);
    return start + half;
  endfunction

endpackage

// File: rtl/sync_hit_cnt.sv
// Saturating sync-byte hit counter for one observation window.
// Ports:
//   clk, rst  - byte clock, asynchronous active-high reset
//   clr       - clears the count (held while the tap settles)
//   hit       - one qualified sync byte this cycle
//   good      - count has reached MIN_HITS
module sync_hit_cnt #(
  parameter int unsigned MIN_HITS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hit,
  output logic good
);

  localparam int unsigned CntW = (MIN_HITS > 0) ? $clog2(MIN_HITS + 1) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q < CntW'(MIN_HITS))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign good = (cnt_q >= CntW'(MIN_HITS));

endmodule

// File: rtl/lane_deskew_ctrl.sv
// Lane deskew calibration controller.
// With DESKEW_SWEEP_EN defined, each lane in turn sweeps IDELAY taps 0..31,
// counts sync bytes per tap and loads the center of the first longest run of
// good taps (or DSKEW, flagging fail, if none). With DESKEW_SWEEP_EN undefined,
// start simply loads DSKEW on every lane, one lane per cycle.
// Ports:
//   clk, rst    - byte clock, asynchronous active-high reset
//   start       - one-cycle calibration request (ignored while running)
//   byte_vld    - per-lane byte strobe from the deserializers
//   byte_data   - per-lane deserialized byte
//   dly_tap     - per-lane IDELAY tap value
//   dly_ld      - per-lane one-cycle tap load strobe (at most one bit high)
//   busy        - calibration in progress
//   done        - sticky completion flag
//   fail        - sticky per-lane "no good tap" flag
module lane_deskew_ctrl
  import lane_deskew_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned OBS_CYC    = 1024,
  parameter int unsigned MIN_HITS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  lane_vld_t  byte_vld,
  input  lane_data_t byte_data,
  output lane_dly_t  dly_tap,
  output lane_vld_t  dly_ld,
  output logic       busy,
  output logic       done,
  output lane_vld_t  fail
);

  deskew_state_e state_q;
  lane_idx_t     lane_q;
  lane_vld_t     lane_bit;

  assign lane_bit = lane_vld_t'(1) << lane_q;

`ifdef DESKEW_SWEEP_EN

  localparam int unsigned CycMax = (SETTLE_CYC > OBS_CYC) ? SETTLE_CYC : OBS_CYC;
  localparam int unsigned CntW   = $clog2(CycMax + 1);

  tap_t            tap_q;
  tap_t            run_start_q;
  tap_t            best_start_q;
  run_t            run_len_q;
  run_t            best_len_q;
  logic [CntW-1:0] cyc_q;

  logic hit;
  logic hit_clr;
  logic tap_good;
  run_t run_len_inc;
  tap_t run_start_nx;

  // Only the lane being calibrated can score hits.
  assign hit     = (state_q == StObserve) && byte_vld[lane_q] && (byte_data[lane_q] == SYNC_BYTE);
  assign hit_clr = (state_q == StSettle);

  sync_hit_cnt #(
    .MIN_HITS(MIN_HITS)
  ) u_sync_hit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (hit_clr),
    .hit (hit),
    .good(tap_good)
  );

  assign run_len_inc  = run_len_q + run_t'(1);
  assign run_start_nx = (run_len_q == '0) ? tap_q : run_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      dly_tap      <= DSKEW;
      dly_ld       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= '0;
      lane_q       <= '0;
      tap_q        <= '0;
      run_start_q  <= '0;
      best_start_q <= '0;
      run_len_q    <= '0;
      best_len_q   <= '0;
      cyc_q        <= '0;
    end else begin
      dly_ld <= '0;
      case (state_q)
        StIdle: begin
          if (start) begin
            done         <= 1'b0;
            fail         <= '0;
            busy         <= 1'b1;
            lane_q       <= '0;
            tap_q        <= '0;
            run_start_q  <= '0;
            best_start_q <= '0;
            run_len_q    <= '0;
            best_len_q   <= '0;
            state_q      <= StLoad;
          end
        end
        StLoad: begin
          dly_tap[lane_q] <= tap_q;
          dly_ld          <= lane_bit;
          cyc_q           <= '0;
          state_q         <= StSettle;
        end
        StSettle: begin
          if (cyc_q == CntW'(SETTLE_CYC - 1)) begin
            cyc_q   <= '0;
            state_q <= StObserve;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        StObserve: begin
          if (cyc_q == CntW'(OBS_CYC - 1)) begin
            cyc_q   <= '0;
            state_q <= StEval;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        StEval: begin
          if (tap_good) begin
            run_start_q <= run_start_nx;
            run_len_q   <= run_len_inc;
            // Strictly greater: an equal-length later run never displaces the first.
            if (run_len_inc > best_len_q) begin
              best_start_q <= run_start_nx;
              best_len_q   <= run_len_inc;
            end
          end else begin
            run_len_q <= '0;
          end
          if (tap_q != MAX_TAP) begin
            tap_q   <= tap_q + 1'b1;
            state_q <= StLoad;
          end else begin
            state_q <= StNext;
          end
        end
        StNext: begin
          dly_ld <= lane_bit;
          if (best_len_q != '0) begin
            dly_tap[lane_q] <= center_tap(best_start_q, best_len_q);
          end else begin
            dly_tap[lane_q] <= DSKEW[lane_q];
            fail[lane_q]    <= 1'b1;
          end
          run_start_q  <= '0;
          best_start_q <= '0;
          run_len_q    <= '0;
          best_len_q   <= '0;
          if (lane_q != lane_idx_t'(NUM_LANE - 1)) begin
            lane_q  <= lane_q + 1'b1;
            tap_q   <= '0;
            state_q <= StLoad;
          end else begin
            // Registered outputs: update here so busy is already low in FINISH.
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StFinish;
          end
        end
        StFinish: begin
          lane_q  <= '0;
          tap_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`else

  // Bypass build: byte inputs and sweep timing are not used.
  logic unused_bytes;
  assign unused_bytes = ^{byte_vld, byte_data};
  localparam int unsigned unused_cfg = SETTLE_CYC + OBS_CYC + MIN_HITS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dly_tap <= DSKEW;
      dly_ld  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= '0;
      lane_q  <= '0;
    end else begin
      dly_ld <= '0;
      case (state_q)
        StIdle: begin
          if (start) begin
            // Lane 0 loads on the accepting edge so done lands NUM_LANE+1 cycles later.
            done       <= 1'b0;
            fail       <= '0;
            busy       <= 1'b1;
            dly_tap[0] <= DSKEW[0];
            dly_ld     <= lane_vld_t'(1);
            if (NUM_LANE > 1) begin
              lane_q  <= lane_idx_t'(1);
              state_q <= StLoad;
            end else begin
              state_q <= StFinish;
            end
          end
        end
        StLoad: begin
          dly_tap[lane_q] <= DSKEW[lane_q];
          dly_ld          <= lane_bit;
          if (lane_q == lane_idx_t'(NUM_LANE - 1)) begin
            state_q <= StFinish;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
        StFinish: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          lane_q  <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_lane_deskew_ctrl.sv
`timescale 1ns/1ps
module tb_lane_deskew_ctrl;
  import lane_deskew_ctrl_pkg::*;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned OBS    = 8;
  localparam int unsigned HITS   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  lane_vld_t  byte_vld;
  lane_data_t byte_data;
  lane_dly_t  dly_tap;
  lane_vld_t  dly_ld;
  logic       busy;
  logic       done;
  lane_vld_t  fail;

  lane_deskew_ctrl #(
    .SETTLE_CYC(SETTLE),
    .OBS_CYC   (OBS),
    .MIN_HITS  (HITS)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .byte_vld (byte_vld),
    .byte_data(byte_data),
    .dly_tap  (dly_tap),
    .dly_ld   (dly_ld),
    .busy     (busy),
    .done     (done),
    .fail     (fail)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int exp_q[$];                    // expected loads, encoded lane*32+tap
  logic [31:0] good_map [NUM_LANE]; // which taps see a clean eye, per lane

  // Channel model: the active lane (last one loaded) shows sync bytes on good
  // taps and only a single stray sync on bad taps; idle lanes spew sync bytes.
  int env_lane = -1;
  int env_tap  = 0;
  int since_ld = 0;
  always @(negedge clk) begin
    if (rst) begin
      env_lane = -1;
      since_ld = 0;
    end else if (dly_ld != '0) begin
      for (int l = 0; l < NUM_LANE; l++) begin
        if (dly_ld[l]) begin
          env_lane = l;
          env_tap  = int'(dly_tap[l]);
        end
      end
      since_ld = 0;
    end else begin
      since_ld++;
    end
    for (int l = 0; l < NUM_LANE; l++) begin
      if (l != env_lane) begin
        byte_vld[l]  = 1'b1;
        byte_data[l] = SYNC_BYTE;
      end else if (good_map[l][env_tap]) begin
        byte_vld[l]  = 1'b1;
        byte_data[l] = SYNC_BYTE;
      end else if (since_ld == int'(SETTLE) + 3) begin
        byte_vld[l]  = 1'b1;
        byte_data[l] = SYNC_BYTE;
      end else begin
        byte_vld[l]  = 1'($urandom);
        byte_data[l] = 8'($urandom);
        if (byte_vld[l] && byte_data[l] == SYNC_BYTE) byte_data[l] = 8'h00;
      end
    end
  end

  // Monitor: pops the scoreboard on every load strobe.
  always @(negedge clk) begin
    if (!rst) begin
      n_total++;
      if (!$onehot0(dly_ld)) begin
        n_bad++;
        $display("FAIL dly_ld_onehot: got %b, required at most one bit", dly_ld);
      end
      for (int l = 0; l < NUM_LANE; l++) begin
        if (dly_ld[l]) begin
          int got;
          int e;
          got = l * 32 + int'(dly_tap[l]);
          n_total++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_load: got lane %0d tap %0d, required none", l, dly_tap[l]);
          end else begin
            e = exp_q.pop_front();
            if (e != got) begin
              n_bad++;
              $display("FAIL load: got lane %0d tap %0d, required lane %0d tap %0d",
                       got / 32, got % 32, e / 32, e % 32);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] span(input int a, input int b);
    logic [31:0] m;
    m = '0;
    for (int t = a; t <= b; t++) m[t] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] rand_map();
    logic [31:0] m;
    int a;
    m = '0;
    if ($urandom_range(0, 4) != 0) begin
      for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
        a = int'($urandom_range(0, 31));
        m |= span(a, (a + int'($urandom_range(0, 7)) > 31) ? 31 : a + int'($urandom_range(0, 7)));
      end
    end
    return m;
  endfunction

  // Reference: widest fully-good window, earliest on ties; load its center.
  function automatic void model_lane(input logic [31:0] g, input int l, output int tap,
                                     output bit f);
    bit ok;
    tap = int'(DSKEW[l]);
    f   = 1'b1;
    for (int len = 32; len >= 1; len--) begin
      for (int a = 0; a + len <= 32; a++) begin
        ok = 1'b1;
        for (int t = a; t < a + len; t++) if (!g[t]) ok = 1'b0;
        if (ok) begin
          tap = a + (len - 1) / 2;
          f   = 1'b0;
          return;
        end
      end
    end
  endfunction

  task automatic push_expect(output lane_dly_t etap, output lane_vld_t efail);
    int t;
    bit f;
    for (int l = 0; l < NUM_LANE; l++) begin
`ifdef DESKEW_SWEEP_EN
      model_lane(good_map[l], l, t, f);
      for (int s = 0; s < 32; s++) exp_q.push_back(l * 32 + s);
`else
      t = int'(DSKEW[l]);
      f = 1'b0;
`endif
      exp_q.push_back(l * 32 + t);
      etap[l]  = 5'(t);
      efail[l] = f;
    end
  endtask

  task automatic run_cal(input string nm, input bit poke);
    lane_dly_t etap;
    lane_vld_t efail;
    int cyc;
    push_expect(etap, efail);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef DESKEW_SWEEP_EN
    cyc = 1;
    while (!done && cyc < 20000) begin
      start = poke && (cyc == 50);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
`else
    for (int k = 1; k <= int'(NUM_LANE) + 1; k++) begin
      chk($sformatf("%s done_at_%0d", nm, k), done, k == int'(NUM_LANE) + 1);
      chk($sformatf("%s busy_at_%0d", nm, k), busy, k <= int'(NUM_LANE));
      start = poke && (k == 2);
      if (k <= int'(NUM_LANE)) @(negedge clk);
    end
    start = 1'b0;
`endif
    chk({nm, " done"}, done, 1'b1);
    @(negedge clk);
    chk({nm, " busy"}, busy, 1'b0);
    chk({nm, " fail"}, fail, efail);
    chk({nm, " dly_tap"}, dly_tap, etap);
    chk({nm, " pending"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk({nm, " done_sticky"}, done, 1'b1);
  endtask

  task automatic run_abort();
    lane_dly_t etap;
    lane_vld_t efail;
    int cyc;
    push_expect(etap, efail);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef DESKEW_SWEEP_EN
    cyc = 0;
    while (!(env_lane == 2 && since_ld == int'(SETTLE) + 2) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort reached_lane2", cyc < 20000, 1'b1);
`else
    @(negedge clk);
`endif
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("abort dly_tap", dly_tap, DSKEW);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort dly_ld", dly_ld, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort idle_busy", busy, 1'b0);
    chk("abort idle_done", done, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int l = 0; l < NUM_LANE; l++) good_map[l] = '0;
    repeat (3) @(negedge clk);
    chk("reset dly_tap", dly_tap, DSKEW);
    chk("reset dly_ld", dly_ld, '0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset fail", fail, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    good_map[0] = span(8, 14);
    for (int l = 1; l < NUM_LANE; l++) good_map[l] = span(10, 20);
    run_cal("nominal", 1'b0);

    good_map[1] = '0;
    run_cal("dead_lane1", 1'b0);

    good_map[0] = rand_map();
    good_map[1] = rand_map();
    good_map[2] = span(2, 4) | span(20, 22);
    good_map[3] = span(28, 31);
    run_cal("tie_and_edge", 1'b0);

    good_map[0] = span(8, 14);
    for (int l = 1; l < NUM_LANE; l++) good_map[l] = span(10, 20);
    run_abort();
    run_cal("after_abort", 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int l = 0; l < NUM_LANE; l++) good_map[l] = rand_map();
      repeat (int'($urandom_range(1, 6))) @(negedge clk);
      run_cal($sformatf("random_%0d", r), r == 1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
